wb_master_mux: RTL and testbench

Master-side bus multiplexer that sits directly downstream of the priority arbiter: it publishes the masters' request vector to the arbiter, takes the arbiter's registered grant index, and routes the granted master onto the shared slave-side Wishbone bus. Terminations (ack/err/rty) are routed back to the granted master only. A one-cycle guard follows every grant change. A watchdog ends any strobe left unterminated for TO_CYCLES cycles with an error to the master, and records the fault.

---
 rtl/wb_master_mux.sv | 203 ++++++++++++++++++++
 tb/tb_wb_master_mux.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_mux.sv
// Master-side Wishbone multiplexer: routes the arbiter-granted master onto the
// shared slave bus, inserts a guard cycle on grant change, and times out stuck strobes.
module wb_master_mux #(
   parameter int NM        = 8,
   parameter int GW        = 3,
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int TO_CYCLES = 255,
   parameter int TOW       = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   output logic [NM-1:0]       req_o,
   input  logic [GW-1:0]       gnt_i,
   input  logic [NM*AW-1:0]    m_adr_i,
   input  logic [NM*DW-1:0]    m_dat_i,
   input  logic [NM*DW/8-1:0]  m_sel_i,
   input  logic [NM-1:0]       m_we_i,
   input  logic [NM-1:0]       m_cyc_i,
   input  logic [NM-1:0]       m_stb_i,
   output logic [DW-1:0]       m_dat_o,
   output logic [NM-1:0]       m_ack_o,
   output logic [NM-1:0]       m_err_o,
   output logic [NM-1:0]       m_rty_o,
   output logic [AW-1:0]       s_adr_o,
   output logic [DW-1:0]       s_dat_o,
   output logic [DW/8-1:0]     s_sel_o,
   output logic                s_we_o,
   output logic                s_cyc_o,
   output logic                s_stb_o,
   input  logic [DW-1:0]       s_dat_i,
   input  logic                s_ack_i,
   input  logic                s_err_i,
   input  logic                s_rty_i,
   output logic                to_flag_o,
   output logic [GW-1:0]       to_master_o,
   input  logic                to_clr_i
);

   localparam int SW = DW / 8;
   localparam logic [TOW-1:0] TO_LIMIT = TOW'(TO_CYCLES);
   localparam logic [GW:0]    NM_LIMIT = (GW + 1)'(NM);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_TIMEOUT = 2'd1,
      ST_HOLD    = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [GW-1:0]   gnt_q, gnt_d;
   logic [TOW-1:0]  wd_q, wd_d;
   logic            to_flag_q, to_flag_d;
   logic [GW-1:0]   to_master_q, to_master_d;

   logic            g_valid_s;
   logic            guard_s;
   logic [NM-1:0]   onehot_s;
   logic            cyc_g_s;
   logic            stb_g_s;
   logic            term_ack_s;
   logic            term_err_s;
   logic            term_rty_s;
   logic            slave_term_s;
   logic            to_entry_s;

   assign req_o        = m_cyc_i;
   assign m_dat_o      = s_dat_i;
   assign g_valid_s    = ({1'b0, gnt_i} < NM_LIMIT);
   assign guard_s      = (gnt_i != gnt_q);
   assign slave_term_s = s_ack_i | s_err_i | s_rty_i;
   assign onehot_s     = g_valid_s ? ({{(NM-1){1'b0}}, 1'b1} << gnt_i) : {NM{1'b0}};

   // AND-OR mux of the granted master; an out-of-range grant selects nothing.
   always_comb begin
      s_adr_o = {AW{1'b0}};
      s_dat_o = {DW{1'b0}};
      s_sel_o = {SW{1'b0}};
      s_we_o  = 1'b0;
      cyc_g_s = 1'b0;
      stb_g_s = 1'b0;
      for (int k = 0; k < NM; k++) begin
         s_adr_o = s_adr_o | ({AW{gnt_i == GW'(k)}} & m_adr_i[k*AW +: AW]);
         s_dat_o = s_dat_o | ({DW{gnt_i == GW'(k)}} & m_dat_i[k*DW +: DW]);
         s_sel_o = s_sel_o | ({SW{gnt_i == GW'(k)}} & m_sel_i[k*SW +: SW]);
         s_we_o  = s_we_o  | ((gnt_i == GW'(k)) & m_we_i[k]);
         cyc_g_s = cyc_g_s | ((gnt_i == GW'(k)) & m_cyc_i[k]);
         stb_g_s = stb_g_s | ((gnt_i == GW'(k)) & m_stb_i[k]);
      end
   end

   // FSM outputs: slave-side handshake and per-state termination routing.
   always_comb begin
      s_cyc_o    = 1'b0;
      s_stb_o    = 1'b0;
      term_ack_s = 1'b0;
      term_err_s = 1'b0;
      term_rty_s = 1'b0;
      case (state_q)
         ST_RUN: begin
            s_cyc_o    = cyc_g_s & ~guard_s & g_valid_s;
            s_stb_o    = stb_g_s & cyc_g_s & ~guard_s & g_valid_s;
            term_ack_s = s_ack_i & s_stb_o;
            term_err_s = s_err_i & s_stb_o;
            term_rty_s = s_rty_i & s_stb_o;
         end
         ST_TIMEOUT: begin
            term_err_s = g_valid_s;
         end
         ST_HOLD: begin
            term_err_s = 1'b0;
         end
         default: begin
            term_err_s = 1'b0;
         end
      endcase
   end

   assign m_ack_o = {NM{term_ack_s}} & onehot_s;
   assign m_err_o = {NM{term_err_s}} & onehot_s;
   assign m_rty_o = {NM{term_rty_s}} & onehot_s;

   // Watchdog counts consecutive unterminated strobe cycles, only while in RUN.
   always_comb begin
      wd_d = {TOW{1'b0}};
      if (state_q == ST_RUN) begin
         if (!s_stb_o || slave_term_s) begin
            wd_d = {TOW{1'b0}};
         end else if (wd_q == TO_LIMIT) begin
            wd_d = wd_q;
         end else begin
            wd_d = wd_q + {{(TOW-1){1'b0}}, 1'b1};
         end
      end else begin
         wd_d = {TOW{1'b0}};
      end
   end

   // Next state; the timeout is taken on the count about to be reached so the
   // error lands exactly TO_CYCLES cycles after the strobe first appeared.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (wd_d == TO_LIMIT) begin
               state_d = ST_TIMEOUT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_TIMEOUT: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (!stb_g_s || guard_s) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Fault record: a new timeout overrides a coincident clear.
   always_comb begin
      gnt_d      = gnt_i;
      to_entry_s = (state_q == ST_RUN) && (state_d == ST_TIMEOUT);
      if (to_entry_s) begin
         to_flag_d   = 1'b1;
         to_master_d = gnt_i;
      end else if (to_clr_i) begin
         to_flag_d   = 1'b0;
         to_master_d = to_master_q;
      end else begin
         to_flag_d   = to_flag_q;
         to_master_d = to_master_q;
      end
   end

   // State register for FSM, grant history, watchdog and fault record.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_RUN;
         gnt_q       <= {GW{1'b0}};
         wd_q        <= {TOW{1'b0}};
         to_flag_q   <= 1'b0;
         to_master_q <= {GW{1'b0}};
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         wd_q        <= wd_d;
         to_flag_q   <= to_flag_d;
         to_master_q <= to_master_d;
      end
   end

   assign to_flag_o   = to_flag_q;
   assign to_master_o = to_master_q;

endmodule

// File: tb/tb_wb_master_mux.sv
// Directed self-checking bench for wb_master_mux (TO_CYCLES = 4).
module tb_wb_master_mux;

   localparam int NM  = 8;
   localparam int GW  = 3;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TOC = 4;
   localparam int TOW = 8;

   logic               clk_i = 1'b0;
   logic               rst_ni;
   logic [NM-1:0]      req_o;
   logic [GW-1:0]      gnt_i;
   logic [NM*AW-1:0]   m_adr_i;
   logic [NM*DW-1:0]   m_dat_i;
   logic [NM*SW-1:0]   m_sel_i;
   logic [NM-1:0]      m_we_i, m_cyc_i, m_stb_i;
   logic [DW-1:0]      m_dat_o;
   logic [NM-1:0]      m_ack_o, m_err_o, m_rty_o;
   logic [AW-1:0]      s_adr_o;
   logic [DW-1:0]      s_dat_o;
   logic [SW-1:0]      s_sel_o;
   logic               s_we_o, s_cyc_o, s_stb_o;
   logic [DW-1:0]      s_dat_i;
   logic               s_ack_i, s_err_i, s_rty_i;
   logic               to_flag_o;
   logic [GW-1:0]      to_master_o;
   logic               to_clr_i;

   int n_cmp = 0;
   int n_bad = 0;

   wb_master_mux #(
      .NM(NM), .GW(GW), .AW(AW), .DW(DW), .TO_CYCLES(TOC), .TOW(TOW)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_o(req_o), .gnt_i(gnt_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
      .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
      .to_flag_o(to_flag_o), .to_master_o(to_master_o), .to_clr_i(to_clr_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_m(input int k, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we, input logic cyc, input logic stb);
      m_adr_i[k*AW +: AW] = adr;
      m_dat_i[k*DW +: DW] = dat;
      m_sel_i[k*SW +: SW] = sel;
      m_we_i[k]  = we;
      m_cyc_i[k] = cyc;
      m_stb_i[k] = stb;
   endtask

   initial begin
      rst_ni = 1'b0; gnt_i = 3'd0; to_clr_i = 1'b0;
      m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
      m_we_i = 8'h00; m_cyc_i = 8'h00; m_stb_i = 8'h00;
      s_dat_i = 32'h0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
      #3;
      chk("rst_flag", {31'd0, to_flag_o}, 32'd0);
      chk("rst_master", {29'd0, to_master_o}, 32'd0);
      chk("rst_cyc", {31'd0, s_cyc_o}, 32'd0);
      chk("rst_err", {24'd0, m_err_o}, 32'd0);
      tick(); tick();

      // Master 0 single read, ack on third cycle
      rst_ni = 1'b1;
      set_m(0, 32'h0000_0100, 32'hA5A5_0000, 4'hF, 1'b0, 1'b1, 1'b1);
      #3;
      chk("rd_req", {24'd0, req_o}, 32'h01);
      chk("rd_adr", s_adr_o, 32'h0000_0100);
      chk("rd_stb", {31'd0, s_stb_o}, 32'd1);
      chk("rd_ack_early", {24'd0, m_ack_o}, 32'h00);
      tick();
      #3;
      chk("rd_wait_stb", {31'd0, s_stb_o}, 32'd1);
      tick();
      s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
      #3;
      chk("rd_ack", {24'd0, m_ack_o}, 32'h01);
      chk("rd_dat", m_dat_o, 32'hDEAD_BEEF);
      chk("rd_err", {24'd0, m_err_o}, 32'h00);
      tick();
      s_ack_i = 1'b0;
      set_m(0, 32'h0000_0100, 32'hA5A5_0000, 4'hF, 1'b0, 1'b0, 1'b0);
      #3;
      chk("rd_idle_ack", {24'd0, m_ack_o}, 32'h00);
      chk("rd_idle_cyc", {31'd0, s_cyc_o}, 32'd0);

      // Grant change 0 -> 3: guard cycle, then master 3 write
      tick();
      gnt_i = 3'd3;
      set_m(3, 32'h0000_0300, 32'h3333_3333, 4'h3, 1'b1, 1'b1, 1'b1);
      s_ack_i = 1'b1;
      #3;
      chk("gc_guard_stb", {31'd0, s_stb_o}, 32'd0);
      chk("gc_guard_cyc", {31'd0, s_cyc_o}, 32'd0);
      chk("gc_guard_ack", {24'd0, m_ack_o}, 32'h00);
      chk("gc_guard_adr", s_adr_o, 32'h0000_0300);
      chk("gc_req", {24'd0, req_o}, 32'h08);
      tick();
      #3;
      chk("gc_stb", {31'd0, s_stb_o}, 32'd1);
      chk("gc_dat", s_dat_o, 32'h3333_3333);
      chk("gc_sel", {28'd0, s_sel_o}, 32'h3);
      chk("gc_we", {31'd0, s_we_o}, 32'd1);
      chk("gc_ack", {24'd0, m_ack_o}, 32'h08);
      tick();
      s_ack_i = 1'b0;
      set_m(3, 32'h0000_0300, 32'h3333_3333, 4'h3, 1'b1, 1'b0, 1'b0);

      // Timeout on master 2; a late ack in the timeout cycle is dropped
      gnt_i = 3'd2;
      tick();
      set_m(2, 32'h0000_0200, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
      #3;
      chk("to_c0_stb", {31'd0, s_stb_o}, 32'd1);
      chk("to_c0_err", {24'd0, m_err_o}, 32'h00);
      tick(); tick(); tick();
      #3;
      chk("to_c3_stb", {31'd0, s_stb_o}, 32'd1);
      chk("to_c3_err", {24'd0, m_err_o}, 32'h00);
      chk("to_c3_flag", {31'd0, to_flag_o}, 32'd0);
      tick();
      s_ack_i = 1'b1;
      #3;
      chk("to_err", {24'd0, m_err_o}, 32'h04);
      chk("to_late_ack", {24'd0, m_ack_o}, 32'h00);
      chk("to_stb", {31'd0, s_stb_o}, 32'd0);
      chk("to_cyc", {31'd0, s_cyc_o}, 32'd0);
      chk("to_flag", {31'd0, to_flag_o}, 32'd1);
      chk("to_master", {29'd0, to_master_o}, 32'd2);
      tick();
      #3;
      chk("hold_stb", {31'd0, s_stb_o}, 32'd0);
      chk("hold_err", {24'd0, m_err_o}, 32'h00);
      chk("hold_ack", {24'd0, m_ack_o}, 32'h00);
      tick();
      s_ack_i = 1'b0;
      set_m(2, 32'h0000_0200, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
      #3;
      chk("hold_cyc", {31'd0, s_cyc_o}, 32'd0);
      tick();
      #3;
      chk("rec_cyc", {31'd0, s_cyc_o}, 32'd1);
      chk("rec_stb_low", {31'd0, s_stb_o}, 32'd0);
      tick();
      set_m(2, 32'h0000_0200, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
      #3;
      chk("rec_stb", {31'd0, s_stb_o}, 32'd1);
      tick();
      set_m(2, 32'h0000_0200, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);

      // Clear with no new timeout
      to_clr_i = 1'b1;
      #3;
      chk("clr_same_cycle", {31'd0, to_flag_o}, 32'd1);
      tick();
      to_clr_i = 1'b0;
      #3;
      chk("clr_flag", {31'd0, to_flag_o}, 32'd0);
      chk("clr_master", {29'd0, to_master_o}, 32'd2);

      // Clear coincident with a new timeout on master 6: set wins
      tick();
      gnt_i = 3'd6;
      tick();
      set_m(6, 32'h0000_0600, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
      tick(); tick(); tick();
      to_clr_i = 1'b1;
      tick();
      to_clr_i = 1'b0;
      #3;
      chk("clr2_err", {24'd0, m_err_o}, 32'h40);
      chk("clr2_flag", {31'd0, to_flag_o}, 32'd1);
      chk("clr2_master", {29'd0, to_master_o}, 32'd6);
      set_m(6, 32'h0000_0600, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
      tick();
      #3;
      chk("clr2_hold_err", {24'd0, m_err_o}, 32'h00);
      chk("clr2_hold_flag", {31'd0, to_flag_o}, 32'd1);

      // Reset mid-burst on master 5
      tick();
      gnt_i = 3'd5;
      tick();
      set_m(5, 32'h0000_0500, 32'h5555_0000, 4'hF, 1'b0, 1'b1, 1'b1);
      #3;
      chk("mb_cyc", {31'd0, s_cyc_o}, 32'd1);
      chk("mb_adr", s_adr_o, 32'h0000_0500);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("mb_rst_cyc", {31'd0, s_cyc_o}, 32'd0);
      chk("mb_rst_stb", {31'd0, s_stb_o}, 32'd0);
      chk("mb_rst_flag", {31'd0, to_flag_o}, 32'd0);
      chk("mb_rst_master", {29'd0, to_master_o}, 32'd0);
      tick();
      rst_ni = 1'b1;
      #3;
      chk("mb_guard_cyc", {31'd0, s_cyc_o}, 32'd0);
      tick();
      s_ack_i = 1'b1;
      #3;
      chk("mb_run_stb", {31'd0, s_stb_o}, 32'd1);
      chk("mb_run_ack", {24'd0, m_ack_o}, 32'h20);
      chk("mb_run_err", {24'd0, m_err_o}, 32'h00);
      tick();
      s_ack_i = 1'b0;
      set_m(5, 32'h0000_0500, 32'h5555_0000, 4'hF, 1'b0, 1'b0, 1'b0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
